// File: rtl/dm_port_arbiter_if.sv
// Data-memory port bundle: core access, DMA burst channel and the memory bus.
// The slave modport is the arbiter's view. The master modport is the view of whoever
// drives the core, the DMA engine and the memory model.
interface dm_port_arbiter_if #(
    parameter int DMA_SIZE = 16,
    parameter int DMD_SIZE = 16
);
    // Core (PS/DAG) side
    logic                ps_dm_cslt;
    logic                ps_dm_wrb;
    logic [DMA_SIZE-1:0] dg_dm_add;
    logic [DMD_SIZE-1:0] bc_dt;
    logic                core_stall;

    // DMA burst side
    logic                dma_req;
    logic                dma_wrb;
    logic [DMA_SIZE-1:0] dma_add;
    logic [7:0]          dma_len;
    logic [DMD_SIZE-1:0] dma_wdt;
    logic                dma_gnt;
    logic                dma_rvld;
    logic [DMD_SIZE-1:0] dma_rdt;
    logic                dma_done;

    // Memory side
    logic                dm_cslt;
    logic                dm_wrb;
    logic [DMA_SIZE-1:0] dm_add;
    logic [DMD_SIZE-1:0] dm_wdt;
    logic [DMD_SIZE-1:0] dm_rdt;

    modport slave (
        input  ps_dm_cslt, ps_dm_wrb, dg_dm_add, bc_dt,
        input  dma_req, dma_wrb, dma_add, dma_len, dma_wdt,
        input  dm_rdt,
        output core_stall, dma_gnt, dma_rvld, dma_rdt, dma_done,
        output dm_cslt, dm_wrb, dm_add, dm_wdt
    );

    modport master (
        output ps_dm_cslt, ps_dm_wrb, dg_dm_add, bc_dt,
        output dma_req, dma_wrb, dma_add, dma_len, dma_wdt,
        output dm_rdt,
        input  core_stall, dma_gnt, dma_rvld, dma_rdt, dma_done,
        input  dm_cslt, dm_wrb, dm_add, dm_wdt
    );
endinterface

// File: rtl/dm_port_arbiter.sv
// Single-port data-memory arbiter between the core and a DMA burst engine.
// The core normally owns the port. A DMA beat takes the port on any cycle the core
// is idle. After STARVE_LIMIT consecutive lost cycles, the beat is forced and the core
// is stalled for that cycle.
module dm_port_arbiter #(
    parameter int DMA_SIZE     = 16,
    parameter int DMD_SIZE     = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    dm_port_arbiter_if.slave  bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t              state_q, state_d;
    logic [DMA_SIZE-1:0] addr_q, addr_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [3:0]          starve_q, starve_d;
    logic                wrb_q, wrb_d;
    logic                rvld_q, rvld_d;
    logic                done_q, done_d;

    logic                dmaBeat;
    logic                coreWin;

    // Decide who owns the memory port this cycle: the DMA beat wins when the core is idle or has been starved out.
    always_comb begin
        dmaBeat = 1'b0;
        coreWin = 1'b0;
        if (state_q == BURST) begin
            if (!bus.ps_dm_cslt || (starve_q >= STARVE_MAX)) begin
                dmaBeat = 1'b1;
            end else begin
                coreWin = 1'b1;
            end
        end
    end

    // Next-state logic plus memory-bus steering; the memory bus follows the core unless a DMA beat is issued.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        starve_d = starve_q;
        wrb_d    = wrb_q;
        rvld_d   = 1'b0;
        done_d   = 1'b0;

        bus.dm_cslt    = bus.ps_dm_cslt;
        bus.dm_wrb     = bus.ps_dm_wrb;
        bus.dm_add     = bus.dg_dm_add;
        bus.dm_wdt     = bus.bc_dt;
        bus.core_stall = 1'b0;
        bus.dma_gnt    = 1'b0;
        bus.dma_rvld   = rvld_q;
        bus.dma_rdt    = rvld_q ? bus.dm_rdt : '0;
        bus.dma_done   = done_q;

        case (state_q)
            IDLE: begin
                starve_d = 4'd0;
                if (bus.dma_req) begin
                    if (bus.dma_len != 8'd0) begin
                        wrb_d   = bus.dma_wrb;
                        addr_d  = bus.dma_add;
                        cnt_d   = bus.dma_len;
                        state_d = BURST;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            BURST: begin
                if (dmaBeat) begin
                    bus.dm_cslt    = 1'b1;
                    bus.dm_wrb     = wrb_q;
                    bus.dm_add     = addr_q;
                    bus.dm_wdt     = bus.dma_wdt;
                    bus.dma_gnt    = 1'b1;
                    bus.core_stall = bus.ps_dm_cslt;
                    addr_d         = addr_q + 1'b1;
                    cnt_d          = cnt_q - 8'd1;
                    starve_d       = 4'd0;
                    rvld_d         = !wrb_q;
                    if (cnt_q == 8'd1) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else if (coreWin) begin
                    starve_d = starve_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and burst registers; reset abandons any burst in flight without a done pulse or pending read return.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            cnt_q    <= 8'd0;
            starve_q <= 4'd0;
            wrb_q    <= 1'b0;
            rvld_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            wrb_q    <= wrb_d;
            rvld_q   <= rvld_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter. Each cycle's bus ownership, grant, stall and done are
// checked against hand-derived values. Expected DMA read data is queued when a read beat
// is driven, and a monitor compares it when dma_rvld rises.
module tb_dm_port_arbiter;

    logic clk;
    logic reset;

    int checks;
    int errors;

    logic [15:0] expQ[$];

    dm_port_arbiter_if #(.DMA_SIZE(16), .DMD_SIZE(16)) bus ();

    dm_port_arbiter #(
        .DMA_SIZE(16),
        .DMD_SIZE(16),
        .STARVE_LIMIT(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] memData(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    // Memory model: read data appears one cycle after any read access.
    always @(posedge clk) begin
        if (bus.dm_cslt === 1'b1 && bus.dm_wrb === 1'b0) begin
            bus.dm_rdt <= memData(bus.dm_add);
        end
    end

    // Scoreboard: every DMA read return must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.dma_rvld === 1'b1) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $error("FAIL rvld_unexpected: got dma_rdt=%h want no dma_rvld", bus.dma_rdt);
            end else begin
                logic [15:0] want;
                want = expQ.pop_front();
                assert (bus.dma_rdt === want) else begin
                    errors++;
                    $error("FAIL rvld_data: got %h want %h", bus.dma_rdt, want);
                end
            end
        end
    end

    task automatic setCore(input logic c, input logic w, input logic [15:0] a, input logic [15:0] d);
        bus.ps_dm_cslt = c;
        bus.ps_dm_wrb  = w;
        bus.dg_dm_add  = a;
        bus.bc_dt      = d;
    endtask

    task automatic setDma(input logic r, input logic w, input logic [15:0] a, input logic [7:0] l, input logic [15:0] d);
        bus.dma_req = r;
        bus.dma_wrb = w;
        bus.dma_add = a;
        bus.dma_len = l;
        bus.dma_wdt = d;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Compare the current cycle's outputs at the falling edge.
    task automatic checkOutput(input string tag, input logic expCslt, input logic expWrb,
                               input logic [15:0] expAdd, input logic [15:0] expWdt,
                               input logic expGnt, input logic expStall,
                               input logic expDone, input logic expRvld);
        @(negedge clk);
        checks++;
        assert (bus.dm_cslt === expCslt) else begin
            errors++;
            $error("FAIL %s dm_cslt: got %b want %b", tag, bus.dm_cslt, expCslt);
        end
        if (expCslt) begin
            checks++;
            assert (bus.dm_wrb === expWrb && bus.dm_add === expAdd) else begin
                errors++;
                $error("FAIL %s dm_wrb/add: got %b/%h want %b/%h", tag, bus.dm_wrb, bus.dm_add, expWrb, expAdd);
            end
            if (expWrb) begin
                checks++;
                assert (bus.dm_wdt === expWdt) else begin
                    errors++;
                    $error("FAIL %s dm_wdt: got %h want %h", tag, bus.dm_wdt, expWdt);
                end
            end
        end
        checks++;
        assert (bus.dma_gnt === expGnt && bus.core_stall === expStall) else begin
            errors++;
            $error("FAIL %s gnt/stall: got %b/%b want %b/%b", tag, bus.dma_gnt, bus.core_stall, expGnt, expStall);
        end
        checks++;
        assert (bus.dma_done === expDone && bus.dma_rvld === expRvld) else begin
            errors++;
            $error("FAIL %s done/rvld: got %b/%b want %b/%b", tag, bus.dma_done, bus.dma_rvld, expDone, expRvld);
        end
        if (!expRvld) begin
            checks++;
            assert (bus.dma_rdt === 16'h0000) else begin
                errors++;
                $error("FAIL %s rdt_idle: got %h want 0000", tag, bus.dma_rdt);
            end
        end
    endtask

    // Directed stimulus sequence.
    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.dm_rdt = 16'h0000;
        setCore(1'b0, 1'b0, 16'h0000, 16'h0000);
        setDma(1'b0, 1'b0, 16'h0000, 8'd0, 16'h0000);
        nextCycle();

        // Reset state: still in reset, everything quiet
        checkOutput("reset", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        nextCycle();

        // Write burst of 3 at 0x0010, core idle
        setDma(1'b1, 1'b1, 16'h0010, 8'd3, 16'h0000);
        checkOutput("wr3_req", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        nextCycle();
        for (int i = 0; i < 3; i++) begin
            setDma(1'b0, 1'b0, 16'h0000, 8'd0, 16'hA000 + 16'(i));
            checkOutput("wr3_beat", 1'b1, 1'b1, 16'h0010 + 16'(i), 16'hA000 + 16'(i), 1'b1, 1'b0, 1'b0, 1'b0);
            nextCycle();
        end
        checkOutput("wr3_done", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        nextCycle();
        checkOutput("wr3_after", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        nextCycle();

        // Read burst of 2 at 0x0200 while the core hammers reads at 0x0300
        setCore(1'b1, 1'b0, 16'h0300, 16'h0000);
        setDma(1'b1, 1'b0, 16'h0200, 8'd2, 16'h0000);
        checkOutput("rd2_req_core", 1'b1, 1'b0, 16'h0300, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        nextCycle();
        setDma(1'b0, 1'b0, 16'h0000, 8'd0, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            checkOutput("rd2_corewin1", 1'b1, 1'b0, 16'h0300, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
            nextCycle();
        end
        expQ.push_back(memData(16'h0200));
        checkOutput("rd2_force1", 1'b1, 1'b0, 16'h0200, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        nextCycle();
        for (int i = 0; i < 4; i++) begin
            checkOutput("rd2_corewin2", 1'b1, 1'b0, 16'h0300, 16'h0, 1'b0, 1'b0, 1'b0, (i == 0));
            nextCycle();
        end
        expQ.push_back(memData(16'h0201));
        checkOutput("rd2_force2", 1'b1, 1'b0, 16'h0201, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        nextCycle();
        checkOutput("rd2_done", 1'b1, 1'b0, 16'h0300, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        nextCycle();
        setCore(1'b0, 1'b0, 16'h0000, 16'h0000);
        checkOutput("rd2_after", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        nextCycle();

        // Address wrap 0xFFFF -> 0x0000, then a back-to-back len=1 request on the done cycle
        setDma(1'b1, 1'b1, 16'hFFFF, 8'd2, 16'h0000);
        checkOutput("wrap_req", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        nextCycle();
        setDma(1'b0, 1'b0, 16'h0000, 8'd0, 16'hB001);
        checkOutput("wrap_beat1", 1'b1, 1'b1, 16'hFFFF, 16'hB001, 1'b1, 1'b0, 1'b0, 1'b0);
        nextCycle();
        setDma(1'b0, 1'b0, 16'h0000, 8'd0, 16'hB002);
        checkOutput("wrap_beat2", 1'b1, 1'b1, 16'h0000, 16'hB002, 1'b1, 1'b0, 1'b0, 1'b0);
        nextCycle();
        setDma(1'b1, 1'b1, 16'h0040, 8'd1, 16'h0000);
        checkOutput("wrap_done_req", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        nextCycle();
        setDma(1'b0, 1'b0, 16'h0000, 8'd0, 16'hC040);
        checkOutput("b2b_beat", 1'b1, 1'b1, 16'h0040, 16'hC040, 1'b1, 1'b0, 1'b0, 1'b0);
        nextCycle();
        checkOutput("b2b_done", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        nextCycle();
        checkOutput("b2b_after", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        nextCycle();

        // Zero-length request: immediate done, no memory access
        setDma(1'b1, 1'b0, 16'h0123, 8'd0, 16'h0000);
        checkOutput("len0_req", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        nextCycle();
        setDma(1'b0, 1'b0, 16'h0000, 8'd0, 16'h0000);
        checkOutput("len0_done", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        nextCycle();
        checkOutput("len0_after", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        nextCycle();

        // Reset in the middle of a 5-beat read burst
        setDma(1'b1, 1'b0, 16'h0500, 8'd5, 16'h0000);
        checkOutput("rd5_req", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        nextCycle();
        setDma(1'b0, 1'b0, 16'h0000, 8'd0, 16'h0000);
        expQ.push_back(memData(16'h0500));
        checkOutput("rd5_beat1", 1'b1, 1'b0, 16'h0500, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        nextCycle();
        expQ.push_back(memData(16'h0501));
        checkOutput("rd5_beat2", 1'b1, 1'b0, 16'h0501, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        nextCycle();
        reset = 1'b1;
        checkOutput("rd5_reset_cyc", 1'b1, 1'b0, 16'h0502, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        nextCycle();
        reset = 1'b0;
        setCore(1'b1, 1'b0, 16'h0600, 16'h0000);
        checkOutput("rd5_post_core", 1'b1, 1'b0, 16'h0600, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        nextCycle();
        setCore(1'b0, 1'b0, 16'h0000, 16'h0000);
        checkOutput("rd5_post_quiet", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        nextCycle();
        checkOutput("rd5_post_quiet2", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        nextCycle();

        // Every queued read return must have been consumed
        checks++;
        assert (expQ.size() === 0) else begin
            errors++;
            $error("FAIL rvld_pending: got %0d outstanding want 0", expQ.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
